// File: rtl/id_dispatch_queue_if.sv
// Decoded-instruction entry type and the decode/dispatch queue interface.
// The queue itself uses the slave modport; the driving side uses master.
package id_dispatch_pkg;
  typedef struct packed {
    logic        inst_valid;
    logic [31:0] pc;
    logic [4:0]  aluop;        // 5'd0 is a plain add, never a branch
    logic        reg_write_en;
    logic [4:0]  dest;
    logic        is_exception;
    logic        pre_is_branch_taken;
    logic [31:0] pre_branch_addr;
  } id_dispatch_t;
endpackage

interface id_dispatch_queue_if #(
  parameter int DEPTH = 8
);
  import id_dispatch_pkg::*;
  localparam int PTR_W = $clog2(DEPTH);

  logic               enq_valid;
  id_dispatch_t       enq_data;
  logic               enq_ready;
  id_dispatch_t       id_dispatch;
  logic               deq_valid;
  logic               pause_dispatch;
  logic               pause_ex;
  logic               branch_flush;
  logic               flush;
  logic [PTR_W:0]     count;

  modport master (
    output enq_valid, enq_data, pause_dispatch, pause_ex, branch_flush, flush,
    input  enq_ready, id_dispatch, deq_valid, count
  );

  modport slave (
    input  enq_valid, enq_data, pause_dispatch, pause_ex, branch_flush, flush,
    output enq_ready, id_dispatch, deq_valid, count
  );
endinterface

// File: rtl/id_dispatch_queue.sv
// Circular instruction queue between decode and dispatch; absorbs dispatch/ex
// stalls, drops wrong-path entries on mispredict and everything on flush.
module id_dispatch_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  id_dispatch_queue_if.slave  q
);
  import id_dispatch_pkg::*;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  id_dispatch_t     r_mem [DEPTH];

  logic w_full, w_empty, w_enq, w_hold, w_deq, w_bflush, w_clear;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_enq    = q.enq_valid && !w_full;
  assign w_hold   = q.pause_dispatch || q.pause_ex;
  assign w_deq    = !w_empty && !w_hold;
  // A paused branch is re-evaluated once the pause drops.
  assign w_bflush = q.branch_flush && !w_empty && !w_hold;
  assign w_clear  = q.flush || w_bflush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_ONE;
      if (w_deq) r_head <= r_head + PTR_ONE;
      r_count <= r_count + {{PTR_W{1'b0}}, w_enq} - {{PTR_W{1'b0}}, w_deq};
    end
  end

  // Storage is deliberately unreset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (w_enq && !w_clear) r_mem[r_tail] <= q.enq_data;
  end

  assign q.enq_ready   = !w_full;
  assign q.deq_valid   = !w_empty;
  assign q.count       = r_count;
  assign q.id_dispatch = w_empty ? '0 : r_mem[r_head];
endmodule

// File: doc/id_dispatch_queue.md
# id_dispatch_queue

Instruction queue between decode and dispatch. It buffers decoded `id_dispatch_t` entries in a circular FIFO and presents the oldest one to dispatch. It absorbs dispatch load-use pauses and ex-stage stalls without stalling decode until full. On a branch mispredict it discards wrong-path entries; on a pipeline flush it discards everything.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`, pointer width; derived, not overridden.

Ports:
- `clk`  input  1  single clock domain; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enq_valid`  input  1  decode presents a valid entry.
- `enq_data`  input  `id_dispatch_t`  decoded entry from decode.
- `enq_ready`  output  1  queue can accept an entry; equals `!full`.
- `id_dispatch`  output  `id_dispatch_t`  head entry to dispatch; all-zero when empty.
- `deq_valid`  output  1  head entry is valid; equals `!empty`.
- `pause_dispatch`  input  1  load-use stall from dispatch; the head is held.
- `pause_ex`  input  1  ex-stage stall; the head is held.
- `branch_flush`  input  1  mispredict flag from dispatch's branch update for the current head.
- `flush`  input  1  exception or ertn flush from control.
- `count`  output  `PTR_W+1`  number of occupied entries.

## Operation
- State:
  - `head` and `tail` pointers, `PTR_W` bits each; they wrap modulo `DEPTH` naturally.
  - `count`, `PTR_W+1` bits.
  - `DEPTH` storage entries; storage is not reset.
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- Define `enq = enq_valid && enq_ready` and `hold = pause_dispatch || pause_ex`.
- Define `deq = !empty && !hold`: the head is consumed by the dispatch→ex register that cycle.
- Define `bflush = branch_flush && !empty && !hold`. `branch_flush` is ignored while `hold` is high or the queue is empty; the branch is re-evaluated when the pause drops.
- Output path:
  - `id_dispatch = empty ? '0 : mem[head]`.
  - The all-zero value carries `inst_valid=0`, `reg_write_en=0`, `is_exception=0` and a non-branch `aluop`, so dispatch emits a bubble.
- Next-state priority, highest first:
  1. `flush`: `head=tail=0`, `count=0`. Any same-cycle enqueue and dequeue are discarded.
  2. `bflush`: the head (the branch) is dequeued and all younger entries are discarded: `head=tail=0`, `count=0`. A same-cycle enqueue is discarded because it is wrong-path.
  3. Otherwise:
     - If `enq`: write `mem[tail]`, then `tail++`.
     - If `deq`: `head++`.
     - `count += enq - deq`.
- Enqueue while full is never accepted, even if a dequeue happens the same cycle. `enq_ready` has no combinational dependence on the stall or flush inputs.
- Enqueue on empty is not bypassed. The entry becomes visible at the head the next cycle.
- Entries leave strictly in program order. `pc`, `pre_is_branch_taken` and `pre_branch_addr` pass through unmodified.

## Timing
- Reset (`rst_n` low, asynchronous, any cycle including mid-operation):
  - `head=tail=0`, `count=0`.
  - Outputs: `deq_valid=0`, `enq_ready=1`, `id_dispatch='0`, `count=0`.
  - Takes effect immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N is presented on `id_dispatch` after edge N, i.e. in cycle N+1, when the queue was empty. Minimum decode-to-dispatch latency is 1 cycle.
- Throughput: one enqueue and one dequeue per cycle. A full queue with a continuous dequeue stream sustains 1 entry/cycle after a 1-cycle `enq_ready` bubble.
- While `hold` is high, `id_dispatch` is stable across cycles unless `flush` asserts.
- A flush or branch flush at edge N gives `empty` in cycle N+1, with `id_dispatch='0` and `enq_ready=1`.
- Wrap-around: after `DEPTH` enqueues, `tail` returns to 0; ordering is preserved across the wrap.

## Test plan
- **Fill and drain.** Reset, then enqueue 8 entries with pc 0x1c000000..0x1c00001c while `pause_ex=1`.
  - Expect `count=8` and `enq_ready=0`.
  - A 9th `enq_valid` is not accepted.
  - Release the pause: pcs emerge in order, one per cycle; `count` reaches 0 and `deq_valid=0`.
- **Load-use hold.** Head pc 0x1c000010 with `pause_dispatch=1` for 2 cycles.
  - Expect `id_dispatch.pc` held at 0x1c000010 for 2 cycles with `count` unchanged.
  - On release, the head advances to 0x1c000014.
- **Branch mispredict.** Queue holds 0x1c000040..0x1c00004c; pulse `branch_flush` with the head at 0x1c000040 while `enq_valid=1` and `hold=0`.
  - Next cycle: `count=0`, `id_dispatch.inst_valid=0`.
  - The same-cycle enqueue is dropped.
  - Repeat with `pause_dispatch=1`: the flush is ignored and `count` is unchanged.
- **Exception flush.** `flush=1` with `count=5` and `enq_valid=1`.
  - Next cycle: `count=0`, `enq_ready=1`.
  - A new enqueue of pc 0x1c008000 appears at the head one cycle later.
- **Wrap and async reset.**
  - Run 20 enqueue/dequeue pairs at 1/cycle: output pcs stay in order across 2 pointer wraps and `count` stays ≤ 1.
  - Drop `rst_n` mid-cycle with `count=3`: `deq_valid` falls before the next edge and `count=0`.
- **Simultaneous enqueue/dequeue at full.** With `count=8`, `pause_ex=0` and `enq_valid=1`:
  - The dequeue occurs and the enqueue is refused, giving `count=7`.
  - The next cycle the enqueue is accepted and `count` stays at 7.
